wall_pixel_renderer: RTL

//  Downstream consumer of the 15x15 wall sprite memory. Tracks the raster

---
 rtl/wall_pkg.sv | 26 ++
 rtl/wall_tile_counter.sv | 69 ++++++
 rtl/wall_pixel_renderer.sv | 85 ++++++++
 3 files changed

// File: rtl/wall_pkg.sv
// Shared constants and types for the wall sprite renderer: sprite geometry,
// RGB type and the four-entry wall palette.
package wall_pkg;

  localparam int WALL_DIM    = 15;
  localparam int WALL_PIXELS = 225;
  localparam int WALL_ADDR_W = 8;

  localparam logic [3:0] WALL_LAST = 4'(WALL_DIM - 1);

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  localparam rgb_t PALETTE [4] = '{
    24'h202020,
    24'h804000,
    24'hC08040,
    24'hFFFFFF
  };

  localparam rgb_t BG_RGB = 24'h000040;

endpackage

// File: rtl/wall_tile_counter.sv
// Raster position tracker in sprite-pixel and tile coordinates; generates the
// sprite read address and the accepted-pixel strobe (start pulses win).
module wall_tile_counter
  import wall_pkg::*;
#(
  parameter int TILES_X = 40,
  parameter int TILES_Y = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic                   pixel_en,
  output logic [WALL_ADDR_W-1:0] rom_addr,
  output logic [5:0]             tile_col,
  output logic [5:0]             tile_row,
  output logic                   pixel_accept
);

  localparam logic [5:0] TX_LIM = 6'(TILES_X);
  localparam logic [5:0] TY_LIM = 6'(TILES_Y);

  logic [3:0]             px;
  logic [3:0]             py;
  logic [5:0]             tx;
  logic [5:0]             ty;
  logic [WALL_ADDR_W-1:0] addr_base;

  assign pixel_accept = pixel_en & ~frame_start & ~line_start;
  assign rom_addr     = addr_base + {4'd0, px};
  assign tile_col     = tx;
  assign tile_row     = ty;

  // addr_base tracks py*WALL_DIM incrementally so no multiplier is needed
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      px        <= '0;
      py        <= '0;
      tx        <= '0;
      ty        <= '0;
      addr_base <= '0;
    end else if (frame_start) begin
      px        <= '0;
      py        <= '0;
      tx        <= '0;
      ty        <= '0;
      addr_base <= '0;
    end else if (line_start) begin
      px <= '0;
      tx <= '0;
      if (py == WALL_LAST) begin
        py        <= '0;
        addr_base <= '0;
        if (ty < TY_LIM) ty <= ty + 6'd1;
      end else begin
        py        <= py + 4'd1;
        addr_base <= addr_base + 8'(WALL_DIM);
      end
    end else if (pixel_en) begin
      if (px == WALL_LAST) begin
        px <= '0;
        if (tx < TX_LIM) tx <= tx + 6'd1;
      end else begin
        px <= px + 4'd1;
      end
    end
  end

endmodule

// File: rtl/wall_pixel_renderer.sv
// Wall sprite renderer: drives the sprite ROM address, gates by the maze wall
// flag and maps the 2-bit colour index to registered RGB (latency 2).
// Option: WALL_RENDER_TRANSPARENT_EN makes colour index 0 render as background.
module wall_pixel_renderer
  import wall_pkg::*;
#(
  parameter int TILES_X = 40,
  parameter int TILES_Y = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       pixel_en,
  output logic [7:0] rom_addr,
  input  logic [1:0] rom_data,
  output logic [5:0] tile_col,
  output logic [5:0] tile_row,
  input  logic       tile_is_wall,
  output logic       pixel_valid,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [5:0] TX_LIM = 6'(TILES_X);
  localparam logic [5:0] TY_LIM = 6'(TILES_Y);

  logic pixel_accept;
  logic s1_valid;
  logic s1_wall;
  rgb_t pix_rgb;
  rgb_t rgb_q;

  wall_tile_counter #(
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y)
  ) u_counter (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .pixel_en     (pixel_en),
    .rom_addr     (rom_addr),
    .tile_col     (tile_col),
    .tile_row     (tile_row),
    .pixel_accept (pixel_accept)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_wall  <= 1'b0;
    end else begin
      s1_valid <= pixel_accept;
      s1_wall  <= tile_is_wall && (tile_col < TX_LIM) && (tile_row < TY_LIM);
    end
  end

  always_comb begin
    pix_rgb = BG_RGB;
    if (s1_wall) begin
      pix_rgb = PALETTE[rom_data];
`ifdef WALL_RENDER_TRANSPARENT_EN
      if (rom_data == 2'd0) pix_rgb = BG_RGB;
`else
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_valid <= 1'b0;
      rgb_q       <= '0;
    end else begin
      pixel_valid <= s1_valid;
      if (s1_valid) rgb_q <= pix_rgb;
    end
  end

  assign red   = rgb_q.red;
  assign green = rgb_q.green;
  assign blue  = rgb_q.blue;

endmodule
